// File: rtl/fetch_if.sv
// fetch_if: fetch control, instruction-memory request/ack bus and fetch status.
interface fetch_if;
    logic        fetch_en;
    logic        branch;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_we;
    logic [31:0] ir_data;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_err;
    modport master (
        output fetch_en, branch, branch_target, mem_ack, mem_rdata,
        input  mem_req, mem_addr, ir_we, ir_data, pc, busy, fetch_err
    );
    modport slave (
        input  fetch_en, branch, branch_target, mem_ack, mem_rdata,
        output mem_req, mem_addr, ir_we, ir_data, pc, busy, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder issuing one memory read per fetch and pulsing IR_WE with the word.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input logic    i_clk,
    input logic    i_rst,
    fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, LOAD, ERR} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_pend_tgt;
    logic        r_pend, r_err;
    logic [7:0]  r_cnt;
    logic [31:0] w_tgt;
    logic        w_timeout;
    assign w_tgt     = bus.branch_target & ~32'h3;
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1)) && !bus.mem_ack;
    always_ff @(posedge i_clk)
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = (!bus.branch && bus.fetch_en) ? WAIT : IDLE;
            WAIT:    w_next = bus.mem_ack ? LOAD : (w_timeout ? ERR : WAIT);
            LOAD:    w_next = IDLE;
            default: w_next = ERR;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.branch)        r_pc  <= w_tgt;
                    else if (bus.fetch_en) r_cnt <= '0;
                end
                WAIT: begin
                    if (bus.branch) begin
                        r_pend     <= 1'b1;
                        r_pend_tgt <= w_tgt;
                    end
                    if (bus.mem_ack) r_ir  <= bus.mem_rdata;
                    else             r_cnt <= r_cnt + 8'd1;
                    if (w_timeout)   r_err <= 1'b1;
                end
                LOAD: begin
                    // a branch arriving in LOAD itself overrides any earlier pending one
                    r_pc   <= bus.branch ? w_tgt : (r_pend ? r_pend_tgt : r_pc + 32'd4);
                    r_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign bus.mem_req   = (r_state == WAIT);
    assign bus.mem_addr  = r_pc;
    assign bus.ir_we     = (r_state == LOAD);
    assign bus.ir_data   = r_ir;
    assign bus.pc        = r_pc;
    assign bus.busy      = (r_state != IDLE);
    assign bus.fetch_err = r_err;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scenario tasks plus randomized fetches against a transaction-level PC model.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;
    fetch_if bus ();
    fetch_if bus2 ();
    instr_fetch_unit dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    instr_fetch_unit #(.RESET_PC(32'h0000_1000), .TIMEOUT_CYCLES(4)) dut_to (.i_clk(clk), .i_rst(rst2), .bus(bus2));
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_pc;
    logic [31:0] o_addr, o_ir, o_pc;
    logic        o_addr_ok, o_req_ok, o_load_req, o_busy;
    int          o_we;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.fetch_en = 0; bus.branch = 0; bus.branch_target = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        bus2.fetch_en = 0; bus2.branch = 0; bus2.branch_target = 0; bus2.mem_ack = 0; bus2.mem_rdata = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1; rst2 = 1;
        tick(); tick();
        rst = 0; rst2 = 0;
        exp_pc = 32'h0;
    endtask

    // The PC after one fetch: last branch seen during WAIT/LOAD wins, else sequential.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input int delay,
            input int b1, input logic [31:0] t1, input int b2, input logic [31:0] t2);
        int last = -1;
        logic [31:0] t = 32'h0;
        if (b1 >= 0 && b1 <= delay + 1) begin last = b1; t = t1; end
        if (b2 >= 0 && b2 <= delay + 1 && b2 >= last) begin last = b2; t = t2; end
        return (last >= 0) ? {t[31:2], 2'b00} : pc + 32'd4;
    endfunction

    // Drives one fetch: ack after `delay` stall cycles; branches at cycle indices b1/b2
    // (0..delay = WAIT cycles, delay+1 = LOAD cycle). Records observations only.
    task automatic run_fetch(input int delay, input logic [31:0] data,
            input int b1, input logic [31:0] t1, input int b2, input logic [31:0] t2);
        o_addr_ok = 1; o_req_ok = 1; o_we = 0; o_addr = 32'hx;
        bus.fetch_en = 1;
        tick();
        bus.fetch_en = 0;
        for (int c = 0; c <= delay; c++) begin
            if (bus.mem_req !== 1'b1) o_req_ok = 0;
            if (c == 0) o_addr = bus.mem_addr;
            else if (bus.mem_addr !== o_addr) o_addr_ok = 0;
            o_we += int'(bus.ir_we);
            bus.branch = (c == b1) || (c == b2);
            bus.branch_target = (c == b2) ? t2 : t1;
            bus.mem_ack = (c == delay);
            bus.mem_rdata = (c == delay) ? data : $urandom;
            tick();
        end
        o_we += int'(bus.ir_we);
        o_ir = bus.ir_data;
        o_load_req = bus.mem_req;
        bus.branch = (delay + 1 == b1) || (delay + 1 == b2);
        bus.branch_target = (delay + 1 == b2) ? t2 : t1;
        bus.mem_ack = 1'($urandom);
        bus.mem_rdata = $urandom;
        tick();
        clear_inputs();
        o_we += int'(bus.ir_we);
        o_pc = bus.pc;
        o_busy = bus.busy;
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want %h", bus.mem_addr, 32'h0); end
        n_cmp++; if ({bus.mem_req, bus.ir_we, bus.busy, bus.fetch_err} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {bus.mem_req, bus.ir_we, bus.busy, bus.fetch_err}); end
        n_cmp++; if (bus.ir_data !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h want %h", bus.ir_data, 32'h0); end
        n_cmp++; if (bus2.pc !== 32'h1000) begin n_err++; $display("FAIL reset_pc_param: got %h want %h", bus2.pc, 32'h1000); end
    endtask

    task automatic test_single;
        do_reset();
        run_fetch(1, 32'h2002_0005, -1, 0, -1, 0);
        n_cmp++; if (o_addr !== 32'h0 || !o_addr_ok || !o_req_ok) begin n_err++; $display("FAIL single_addr: got %h ok=%b req=%b want 00000000", o_addr, o_addr_ok, o_req_ok); end
        n_cmp++; if (o_we !== 1) begin n_err++; $display("FAIL single_we: got %0d want 1", o_we); end
        n_cmp++; if (o_ir !== 32'h2002_0005) begin n_err++; $display("FAIL single_ir: got %h want %h", o_ir, 32'h2002_0005); end
        n_cmp++; if (o_pc !== 32'h4 || o_busy !== 1'b0) begin n_err++; $display("FAIL single_pc: got %h busy=%b want 00000004", o_pc, o_busy); end
        tick();
        n_cmp++; if (bus.ir_data !== 32'h2002_0005) begin n_err++; $display("FAIL single_ir_hold: got %h want %h", bus.ir_data, 32'h2002_0005); end
    endtask

    task automatic test_back_to_back;
        int delays[3] = '{1, 4, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d = $urandom;
            run_fetch(delays[i], d, -1, 0, -1, 0);
            n_cmp++; if (o_addr !== 32'(4 * i) || !o_addr_ok) begin n_err++; $display("FAIL b2b_addr%0d: got %h want %h", i, o_addr, 32'(4 * i)); end
            n_cmp++; if (o_we !== 1 || o_ir !== d) begin n_err++; $display("FAIL b2b_ir%0d: got we=%0d ir=%h want we=1 ir=%h", i, o_we, o_ir, d); end
        end
        n_cmp++; if (o_pc !== 32'd12) begin n_err++; $display("FAIL b2b_pc: got %h want %h", o_pc, 32'd12); end
    endtask

    task automatic test_branch_idle;
        do_reset();
        bus.fetch_en = 1; bus.branch = 1; bus.branch_target = 32'h0000_0103;
        tick();
        clear_inputs();
        n_cmp++; if (bus.pc !== 32'h100 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_branch: got pc=%h req=%b busy=%b want pc=00000100 req=0 busy=0", bus.pc, bus.mem_req, bus.busy); end
        tick();
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL idle_branch_noreq: got %b want 0", bus.mem_req); end
        run_fetch(0, 32'hCAFE_0001, -1, 0, -1, 0);
        n_cmp++; if (o_addr !== 32'h100 || o_pc !== 32'h104) begin n_err++; $display("FAIL idle_branch_fetch: got addr=%h pc=%h want 00000100/00000104", o_addr, o_pc); end
    endtask

    task automatic test_branch_wait;
        do_reset();
        run_fetch(0, 32'h1, -1, 0, -1, 0);
        run_fetch(0, 32'h2, -1, 0, -1, 0);
        run_fetch(3, 32'hBEEF_0008, 1, 32'h40, 2, 32'h80);
        n_cmp++; if (o_addr !== 32'h8 || o_ir !== 32'hBEEF_0008 || o_we !== 1) begin n_err++; $display("FAIL wait_branch_deliver: got addr=%h ir=%h we=%0d want 00000008/beef0008/1", o_addr, o_ir, o_we); end
        n_cmp++; if (o_pc !== 32'h80) begin n_err++; $display("FAIL wait_branch_pc: got %h want %h", o_pc, 32'h80); end
        run_fetch(0, 32'h3, 1, 32'h203, -1, 0);
        n_cmp++; if (o_addr !== 32'h80 || o_pc !== 32'h200) begin n_err++; $display("FAIL load_branch_pc: got addr=%h pc=%h want 00000080/00000200", o_addr, o_pc); end
    endtask

    task automatic test_timeout;
        int req_cnt = 0;
        int err_at = -1;
        logic quiet = 1;
        do_reset();
        bus2.fetch_en = 1;
        tick();
        bus2.fetch_en = 0;
        for (int s = 0; s < 8; s++) begin
            if (bus2.mem_req === 1'b1) req_cnt++;
            if (err_at < 0 && bus2.fetch_err === 1'b1) err_at = s;
            tick();
        end
        n_cmp++; if (req_cnt !== 4) begin n_err++; $display("FAIL timeout_req_cycles: got %0d want 4", req_cnt); end
        n_cmp++; if (err_at !== 4) begin n_err++; $display("FAIL timeout_err_cycle: got %0d want 4", err_at); end
        for (int s = 0; s < 4; s++) begin
            bus2.fetch_en = 1; bus2.mem_ack = 1; bus2.branch = 1; bus2.branch_target = $urandom;
            tick();
            if (bus2.mem_req !== 1'b0 || bus2.ir_we !== 1'b0 || bus2.fetch_err !== 1'b1 || bus2.pc !== 32'h1000) quiet = 0;
        end
        clear_inputs();
        n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL err_ignores_inputs: got %b want 1", quiet); end
        rst2 = 1; tick(); rst2 = 0;
        n_cmp++; if (bus2.fetch_err !== 1'b0 || bus2.pc !== 32'h1000 || bus2.busy !== 1'b0) begin n_err++; $display("FAIL err_reset: got err=%b pc=%h busy=%b want 0/00001000/0", bus2.fetch_err, bus2.pc, bus2.busy); end
        bus2.fetch_en = 1;
        tick();
        bus2.fetch_en = 0;
        for (int s = 0; s < 3; s++) tick();
        bus2.mem_ack = 1; bus2.mem_rdata = 32'h1234_5678;
        tick();
        clear_inputs();
        n_cmp++; if (bus2.ir_we !== 1'b1 || bus2.fetch_err !== 1'b0 || bus2.ir_data !== 32'h1234_5678) begin n_err++; $display("FAIL last_cycle_ack: got we=%b err=%b ir=%h want 1/0/12345678", bus2.ir_we, bus2.fetch_err, bus2.ir_data); end
        tick();
        n_cmp++; if (bus2.pc !== 32'h1004) begin n_err++; $display("FAIL last_cycle_ack_pc: got %h want %h", bus2.pc, 32'h1004); end
    endtask

    task automatic test_rst_wait_and_wrap;
        do_reset();
        bus.branch = 1; bus.branch_target = 32'h20;
        tick();
        clear_inputs();
        bus.fetch_en = 1;
        tick();
        bus.fetch_en = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.pc !== 32'h0) begin n_err++; $display("FAIL rst_mid_wait: got req=%b busy=%b pc=%h want 0/0/00000000", bus.mem_req, bus.busy, bus.pc); end
        bus.branch = 1; bus.branch_target = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        run_fetch(2, 32'hA5A5_A5A5, -1, 0, -1, 0);
        n_cmp++; if (o_addr !== 32'hFFFF_FFFC || o_pc !== 32'h0) begin n_err++; $display("FAIL pc_wrap: got addr=%h pc=%h want fffffffc/00000000", o_addr, o_pc); end
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int delay, b1, b2;
            logic [31:0] t1, t2, data, nxt;
            if ($urandom_range(0, 3) == 0) begin
                t1 = $urandom;
                bus.branch = 1; bus.branch_target = t1; bus.fetch_en = 1'($urandom);
                tick();
                clear_inputs();
                exp_pc = {t1[31:2], 2'b00};
                n_cmp++; if (bus.pc !== exp_pc || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rnd_idle_branch%0d: got pc=%h req=%b want %h/0", i, bus.pc, bus.mem_req, exp_pc); end
            end
            delay = $urandom_range(0, 6);
            b1 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, delay + 1) : -1;
            b2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, delay + 1) : -1;
            t1 = $urandom; t2 = $urandom; data = $urandom;
            nxt = model_next(exp_pc, delay, b1, t1, b2, t2);
            run_fetch(delay, data, b1, t1, b2, t2);
            n_cmp++; if (o_addr !== exp_pc || !o_addr_ok || !o_req_ok || o_load_req !== 1'b0) begin n_err++; $display("FAIL rnd_addr%0d: got %h ok=%b req=%b want %h", i, o_addr, o_addr_ok, o_req_ok, exp_pc); end
            n_cmp++; if (o_we !== 1 || o_ir !== data) begin n_err++; $display("FAIL rnd_ir%0d: got we=%0d ir=%h want 1/%h", i, o_we, o_ir, data); end
            n_cmp++; if (o_pc !== nxt || o_busy !== 1'b0) begin n_err++; $display("FAIL rnd_pc%0d: got %h busy=%b want %h", i, o_pc, o_busy, nxt); end
            exp_pc = nxt;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_branch_idle();
        test_branch_wait();
        test_timeout();
        test_rst_wait_and_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
